pi_compensator: RTL

- Digital PI compensator for the closed-loop converter. It consumes one offset-binary error sample per conversion from the ADC readback stage (Vout channel error, M+1 bits) and produces a clamped PWM duty word for the DPWM stage.
- Multi-cycle sequential datapath: one shared multiplier path and a saturating integrator with conditional-integration anti-windup.
- Ready/valid handshake on the input and a one-cycle valid strobe on the output.

---
 rtl/pi_compensator.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pi_compensator.sv
// PI compensator: offset-binary error in, clamped DPWM duty word out.
// Six-state sequential datapath sharing one multiplier, with anti-windup.
//
// Ports:
//   CLK, RSTp            clock, async active-high reset
//   ERR_IN/ERR_VALID     offset-binary error sample and strobe
//   ERR_READY            high in IDLE only
//   KP, KI               unsigned gains (FRAC fractional bits), latched at accept
//   CLR_INT              synchronous integrator clear
//   DUTY/DUTY_VALID      registered duty and one-cycle update strobe
//   SAT_HI/SAT_LO        last result clamped high/low
//   OVERRUN              sticky: sample offered while busy
module pi_compensator #(
    parameter int ERR_W     = 9,
    parameter int COEF_W    = 8,
    parameter int FRAC      = 6,
    parameter int INT_W     = 20,
    parameter int DUTY_W    = 8,
    parameter int DUTY_BIAS = 128,
    parameter int DUTY_MIN  = 0,
    parameter int DUTY_MAX  = 255
) (
    input  logic              CLK,
    input  logic              RSTp,
    input  logic [ERR_W-1:0]  ERR_IN,
    input  logic              ERR_VALID,
    output logic              ERR_READY,
    input  logic [COEF_W-1:0] KP,
    input  logic [COEF_W-1:0] KI,
    input  logic              CLR_INT,
    output logic [DUTY_W-1:0] DUTY,
    output logic              DUTY_VALID,
    output logic              SAT_HI,
    output logic              SAT_LO,
    output logic              OVERRUN
);

    localparam int P_W = ERR_W + COEF_W + 1;
    localparam int S_W = INT_W + 1;
    localparam int U_W = INT_W + 2;

    localparam logic signed [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic signed [U_W-1:0]   U_MAX   = U_W'(DUTY_MAX);
    localparam logic signed [U_W-1:0]   U_MIN   = U_W'(DUTY_MIN);
    localparam logic signed [U_W-1:0]   U_BIAS  = U_W'(DUTY_BIAS);

    typedef enum logic [2:0] {
        IDLE, MUL_P, MUL_I, SUM, CLAMP, DONE
    } state_t;

    state_t state, state_nxt;
    logic   accept;

    logic signed [ERR_W-1:0] e_q;
    logic [COEF_W-1:0]       kp_q, ki_q;
    logic signed [P_W-1:0]   p_q, kprod_q;
    logic signed [INT_W-1:0] it_q, integ;
    logic signed [U_W-1:0]   u_q;
    logic [DUTY_W-1:0]       d_q;
    logic                    clr_pend;

    logic [COEF_W-1:0]       coef;
    logic signed [P_W-1:0]   mul_a, mul_b, prod;
    logic signed [S_W-1:0]   isum;
    logic                    ovf;
    logic signed [INT_W-1:0] it_nxt;
    logic signed [U_W-1:0]   pi_sum, u_nxt;
    logic                    hi, lo, hold, ki_pos, ki_neg;
    logic [DUTY_W-1:0]       d_nxt;

    always_ff @(posedge CLK or posedge RSTp) begin
        if (RSTp) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ERR_READY = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                ERR_READY = 1'b1;
                if (ERR_VALID) begin
                    accept    = 1'b1;
                    state_nxt = MUL_P;
                end
            end
            MUL_P:   state_nxt = MUL_I;
            MUL_I:   state_nxt = SUM;
            SUM:     state_nxt = CLAMP;
            CLAMP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shared multiplier: KP in MUL_P, KI in MUL_I.
    always_comb begin
        coef  = (state == MUL_I) ? ki_q : kp_q;
        mul_a = P_W'($signed({1'b0, coef}));
        mul_b = P_W'(e_q);
        prod  = mul_a * mul_b;
    end

    // Saturating integrator update and PI sum with floor shift.
    always_comb begin
        isum   = S_W'(integ) + S_W'(kprod_q);
        ovf    = isum[S_W-1] ^ isum[S_W-2];
        if (ovf) it_nxt = isum[S_W-1] ? INT_MIN : INT_MAX;
        else     it_nxt = isum[INT_W-1:0];
        pi_sum = U_W'(p_q) + U_W'(it_nxt);
        u_nxt  = (pi_sum >>> FRAC) + U_BIAS;
    end

    always_comb begin
        hi     = (u_q > U_MAX);
        lo     = (u_q < U_MIN);
        if (hi)      d_nxt = DUTY_W'(DUTY_MAX);
        else if (lo) d_nxt = DUTY_W'(DUTY_MIN);
        else         d_nxt = u_q[DUTY_W-1:0];
        ki_neg = kprod_q[P_W-1];
        ki_pos = !kprod_q[P_W-1] && (|kprod_q);
        // Freeze the integrator while it would push further into a clamp.
        hold   = (hi && ki_pos) || (lo && ki_neg);
    end

    always_ff @(posedge CLK or posedge RSTp) begin
        if (RSTp) begin
            e_q        <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            p_q        <= '0;
            kprod_q    <= '0;
            it_q       <= '0;
            u_q        <= '0;
            d_q        <= DUTY_W'(DUTY_MIN);
            integ      <= '0;
            clr_pend   <= 1'b0;
            DUTY       <= DUTY_W'(DUTY_MIN);
            DUTY_VALID <= 1'b0;
            SAT_HI     <= 1'b0;
            SAT_LO     <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            DUTY_VALID <= 1'b0;
            if (ERR_VALID && state != IDLE) OVERRUN <= 1'b1;
            // A clear seen while busy is applied at the next commit.
            if (CLR_INT && state != IDLE) clr_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (CLR_INT || clr_pend) begin
                        integ    <= '0;
                        clr_pend <= 1'b0;
                    end
                    if (accept) begin
                        e_q  <= {~ERR_IN[ERR_W-1], ERR_IN[ERR_W-2:0]};
                        kp_q <= KP;
                        ki_q <= KI;
                    end
                end
                MUL_P: p_q     <= prod;
                MUL_I: kprod_q <= prod;
                SUM: begin
                    it_q <= it_nxt;
                    u_q  <= u_nxt;
                end
                CLAMP: begin
                    d_q    <= d_nxt;
                    SAT_HI <= hi;
                    SAT_LO <= lo;
                    if (clr_pend || CLR_INT) begin
                        integ    <= '0;
                        clr_pend <= 1'b0;
                    end else if (!hold) begin
                        integ <= it_q;
                    end
                end
                DONE: begin
                    DUTY       <= d_q;
                    DUTY_VALID <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
